// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: state encodings, reset PC default and alignment helper for the fetch stage
package ifu_fetch_pkg;
  localparam logic [1:0] IFU_IDLE = 2'd0;
  localparam logic [1:0] IFU_WAIT = 2'd1;
  localparam logic [1:0] IFU_HOLD = 2'd2;
  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
  function automatic logic misaligned(input logic [1:0] lsb);
    return |lsb;
  endfunction
endpackage

// File: rtl/ifu_pc_reg.sv
// ifu_pc_reg: program counter with reset, +4 advance and redirect-load priority
module ifu_pc_reg
  import ifu_fetch_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            advance_i,
  output logic [XLEN-1:0] pc_o
);
  logic [XLEN-1:0] pc_q, pc_d;
  always_comb pc_d = redirect_i ? redirect_pc_i : advance_i ? pc_q + XLEN'(4) : pc_q;
  always_ff @(posedge clk) pc_q <= !rst ? RESET_PC : pc_d;
  assign pc_o = pc_q;
endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage with one outstanding read, buffered output and redirect squash
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            resp_valid,
  input  logic [XLEN-1:0] resp_data,
  input  logic            resp_err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            out_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);
  logic [1:0] state_q, state_d;
  logic drop_q, drop_d, err_q, err_d;
  logic [XLEN-1:0] instr_q, instr_d, bpc_q, bpc_d, pc;
  logic req_hs, capture, advance;
  assign req_valid = rst && state_q == IFU_IDLE;
  assign req_addr  = pc;
  assign out_valid = rst && state_q == IFU_HOLD && !redirect_valid;
  assign out_instr = instr_q;
  assign out_pc    = bpc_q;
  assign out_err   = err_q;
  assign req_hs    = req_valid && req_ready;
  assign capture   = state_q == IFU_WAIT && resp_valid && !drop_q && !redirect_valid;
  assign advance   = out_valid && out_ready;
  ifu_pc_reg #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc (
    .clk(clk), .rst(rst), .redirect_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .advance_i(advance), .pc_o(pc)
  );
  always_comb begin
    state_d = redirect_valid ? ((req_hs || (state_q == IFU_WAIT && !resp_valid)) ? IFU_WAIT : IFU_IDLE)
            : state_q == IFU_IDLE ? (req_hs ? IFU_WAIT : IFU_IDLE)
            : state_q == IFU_WAIT ? (resp_valid ? (drop_q ? IFU_IDLE : IFU_HOLD) : IFU_WAIT)
            : (state_q == IFU_HOLD && !out_ready) ? IFU_HOLD : IFU_IDLE;
    drop_d  = (state_q == IFU_WAIT && resp_valid) ? 1'b0
            : (redirect_valid && (req_hs || state_q == IFU_WAIT)) ? 1'b1 : drop_q;
    instr_d = capture ? resp_data : instr_q;
    bpc_d   = capture ? pc : bpc_q;
    err_d   = capture ? (resp_err || misaligned(pc[1:0])) : err_q;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state_q <= IFU_IDLE;
      drop_q  <= 1'b0;
      instr_q <= '0;
      bpc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      instr_q <= instr_d;
      bpc_q   <= bpc_d;
      err_q   <= err_d;
    end
`ifdef IFU_ABORT_EN
`ifndef ABORT
`define ABORT 0
`endif
  function automatic void ebreak(input int station, input int inst);
    $display("ifu_fetch: fault pc=%h", inst);
  endfunction
  always_ff @(posedge clk)
    if (rst) begin
      if (capture && resp_err) ebreak(`ABORT, int'(pc));
      if (redirect_valid && misaligned(redirect_pc[1:0])) ebreak(`ABORT, int'(redirect_pc));
    end
`endif
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed scenarios plus random traffic checked against a transaction-level model
module tb_ifu_fetch;
  localparam logic [31:0] RPC = 32'h8000_0000;
  logic clk = 0, rst = 0, req_ready = 0, resp_valid = 0, resp_err = 0, out_ready = 0, redirect_valid = 0;
  logic req_valid, out_valid, out_err;
  logic [31:0] req_addr, out_instr, out_pc, resp_data = 0, redirect_pc = 0;
  always #5 clk = ~clk;
  ifu_fetch dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_err(out_err), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );
  int checks = 0, passed = 0, cyc = 0;
  logic [31:0] m_pc = RPC, m_addr = 0, m_bi = 0, m_bp = 0;
  bit m_out, m_stale, m_buf, m_be;
  bit mem_busy, mem_err;
  int mem_cnt;
  logic [31:0] mem_data;
  int lat = 1;
  bit rand_data = 0, err_next = 0, stray_en = 0;
  logic [31:0] fix_data = 32'h0010_0093;
  logic [31:0] req_log[$], out_log_pc[$], out_log_i[$];
  int req_cyc[$];
  bit out_log_e[$];
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic step();
    bit ev, eo, rv;
    @(negedge clk);
    resp_valid = 0;
    resp_err = 0;
    if (mem_busy && mem_cnt == 0) begin
      resp_valid = 1; resp_data = mem_data; resp_err = mem_err;
    end else if (stray_en && !mem_busy && $urandom_range(15) == 0) begin
      resp_valid = 1; resp_data = $urandom; resp_err = 1'($urandom_range(1));
    end
    #1;
    ev = rst && !m_out && !m_buf;
    eo = rst && m_buf && !redirect_valid;
    chk("req_valid", req_valid, ev);
    if (ev) chk("req_addr", req_addr, m_pc);
    chk("out_valid", out_valid, eo);
    if (rst && m_buf) begin
      chk("out_instr", out_instr, m_bi);
      chk("out_pc", out_pc, m_bp);
      chk("out_err", out_err, m_be);
    end
    rv = req_valid && req_ready;
    if (rv) begin req_log.push_back(req_addr); req_cyc.push_back(cyc); end
    if (out_valid && out_ready) begin
      out_log_pc.push_back(out_pc); out_log_i.push_back(out_instr); out_log_e.push_back(out_err);
    end
    @(posedge clk);
    cyc++;
    if (!rst) begin
      m_pc = RPC; m_out = 0; m_buf = 0;
    end else if (redirect_valid) begin
      if (m_out && resp_valid) m_out = 0;
      else if (m_out) m_stale = 1;
      if (ev && req_ready) begin m_out = 1; m_stale = 1; m_addr = m_pc; end
      m_buf = 0;
      m_pc = redirect_pc;
    end else begin
      if (m_out && resp_valid) begin
        m_out = 0;
        if (!m_stale) begin
          m_buf = 1; m_bi = resp_data; m_bp = m_addr; m_be = resp_err || m_addr[1:0] != 0;
        end
      end
      if (ev && req_ready) begin m_out = 1; m_stale = 0; m_addr = m_pc; end
      if (eo && out_ready) begin m_buf = 0; m_pc = m_pc + 4; end
    end
    if (mem_busy && mem_cnt == 0) mem_busy = 0;
    else if (mem_busy) mem_cnt--;
    if (rv) begin
      mem_busy = 1; mem_cnt = lat - 1; mem_data = rand_data ? $urandom : fix_data; mem_err = err_next;
    end
    #1;
  endtask
  task automatic wait_req(int n);
    for (int i = 0; i < 30 && req_log.size() < n; i++) step();
    chk("req_count", req_log.size(), n);
  endtask
  task automatic wait_out(int n);
    for (int i = 0; i < 30 && out_log_pc.size() < n; i++) step();
    chk("out_count", out_log_pc.size(), n);
  endtask
  task automatic wait_buf();
    for (int i = 0; i < 30 && !m_buf; i++) step();
    chk("reach_hold", m_buf, 1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int n, no;
    logic [31:0] r;
    step(); step();
    chk("rst_instr", out_instr, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_err", out_err, 0);
    req_log.delete(); req_cyc.delete();
    rst = 1; req_ready = 1; out_ready = 1;
    repeat (9) step();
    chk("t1_nreq", req_log.size(), 3);
    chk("t1_req0", req_log[0], 32'h8000_0000);
    chk("t1_req1", req_log[1], 32'h8000_0004);
    chk("t1_req2", req_log[2], 32'h8000_0008);
    chk("t1_rate", req_cyc[1] - req_cyc[0], 3);
    chk("t1_opc0", out_log_pc[0], 32'h8000_0000);
    chk("t1_oi0", out_log_i[0], 32'h0010_0093);
    chk("t1_opc1", out_log_pc[1], 32'h8000_0004);
    chk("t1_model_pc", m_pc, 32'h8000_000C);
    out_ready = 0;
    wait_buf();
    n = req_log.size();
    repeat (5) step();
    chk("t2_noreq", req_log.size(), n);
    chk("t2_valid", out_valid, 1);
    chk("t2_pc", out_pc, 32'h8000_000C);
    err_next = 1;
    out_ready = 1;
    step();
    chk("t2_acc_pc", out_log_pc[out_log_pc.size() - 1], 32'h8000_000C);
    wait_req(n + 1);
    chk("t2_next_req", req_log[n], 32'h8000_0010);
    no = out_log_pc.size();
    wait_out(no + 1);
    err_next = 0;
    chk("t5_pc", out_log_pc[no], 32'h8000_0010);
    chk("t5_err", out_log_e[no], 1);
    n = req_log.size();
    lat = 3;
    wait_req(n + 1);
    redirect_valid = 1; redirect_pc = 32'h8000_0100;
    step();
    redirect_valid = 0;
    no = out_log_pc.size();
    wait_req(n + 2);
    chk("t3_redir_req", req_log[n + 1], 32'h8000_0100);
    chk("t3_dropped", out_log_pc.size(), no);
    chk("t3_model_pc", m_pc, 32'h8000_0100);
    lat = 1; out_ready = 0;
    wait_buf();
    no = out_log_pc.size();
    n = req_log.size();
    out_ready = 1; redirect_valid = 1; redirect_pc = 32'h8000_0200;
    step();
    redirect_valid = 0;
    chk("t4_no_accept", out_log_pc.size(), no);
    wait_req(n + 1);
    chk("t4_redir_req", req_log[n], 32'h8000_0200);
    req_ready = 0; redirect_valid = 1; redirect_pc = 32'h8000_0302;
    step();
    redirect_valid = 0; req_ready = 1;
    no = out_log_pc.size();
    wait_out(no + 1);
    chk("mis_pc", out_log_pc[no], 32'h8000_0302);
    chk("mis_err", out_log_e[no], 1);
    req_ready = 0; redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 0; req_ready = 1;
    n = req_log.size();
    wait_req(n + 2);
    chk("wrap_req0", req_log[n], 32'hFFFF_FFFC);
    chk("wrap_req1", req_log[n + 1], 32'h0000_0000);
    lat = 3; fix_data = 32'hDEAD_0000;
    n = req_log.size();
    wait_req(n + 1);
    step();
    rst = 0;
    step();
    rst = 1; fix_data = 32'hCAFE_0001; lat = 1;
    no = out_log_pc.size();
    wait_out(no + 1);
    chk("t6_pc", out_log_pc[no], RPC);
    chk("t6_instr", out_log_i[no], 32'hCAFE_0001);
    stray_en = 1; rand_data = 1;
    for (int i = 0; i < 3000; i++) begin
      req_ready = $urandom_range(3) != 0;
      out_ready = 1'($urandom_range(1));
      lat = $urandom_range(3, 1);
      err_next = $urandom_range(7) == 0;
      redirect_valid = $urandom_range(19) == 0;
      r = $urandom;
      redirect_pc = ($urandom_range(3) == 0) ? r : {r[31:2], 2'b00};
      rst = $urandom_range(299) != 0;
      step();
    end
    rst = 1; redirect_valid = 0;
    step();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
